y86_alu_pipe: RTL and testbench
===============================

# y86_alu_pipe

- Parametrised, two-stage pipelined ALU for the Y86-64 execute stage.
- Replaces the standalone combinational subtractor.
- Supports the four Y86 OPq functions (add, sub, and, xor) at any width, with valid/ready handshakes on both sides.
- Holds a ZF/SF/OF condition-code register that results update on request, and evaluates the seven Y86 jXX/cmovXX conditions from that register.

## Interface
- WIDTH, 64, operand/result width in bits (≥ 2)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operation offered
- in_ready  out  1  stage 1 can accept this cycle
- in_a  in  WIDTH  first operand (Y86: valB)
- in_b  in  WIDTH  second operand (Y86: valA)
- in_fun  in  2  0 = add, 1 = sub, 2 = and, 3 = xor
- in_set_cc  in  1  update CC when this result is accepted downstream
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_result  out  WIDTH  computed result
- out_of  out  1  signed overflow of out_result (0 for and/xor)
- cc_zf, cc_sf, cc_of  out  1 each  condition-code register
- cond_fun  in  3  Y86 condition code: 0 always, 1 le, 2 l, 3 e, 4 ne, 5 ge, 6 g, 7 reserved
- cond_true  out  1  condition evaluated against the current CC register (combinational)

## Operation
**Arithmetic**
- add: a + b.
- sub: a − b (Y86 `subq rA,rB` ⇒ in_a = rB, in_b = rA).
- Both are mod 2^WIDTH.
- Overflow:
  - add: OF = (a[MSB] == b[MSB]) && (r[MSB] != a[MSB]).
  - sub: OF = (a[MSB] != b[MSB]) && (r[MSB] != a[MSB]).
- and/xor: bitwise, OF = 0.

**Pipeline**
- Stage 1 registers a, b, fun, set_cc.
- Stage 2 registers result, OF, set_cc.
- Each stage has its own valid bit.
- Stage 2 loads when it is empty or out_ready = 1.
- Stage 1 loads when it is empty or stage 2 loads.
- in_ready = !s1_valid || s2_load.
- A stage whose successor does not load holds all its contents unchanged.

**Condition-code register**
- Updates only on the cycle out_valid && out_ready && s2_set_cc.
- Update values: ZF = (result == 0), SF = result[MSB], OF = out_of.
- Otherwise CC holds its value.

**cond_true**
- 0: 1
- 1: (SF^OF)|ZF
- 2: SF^OF
- 3: ZF
- 4: !ZF
- 5: !(SF^OF)
- 6: !(SF^OF)&!ZF
- 7: 0

**Reset**
- s1_valid = s2_valid = 0.
- out_result = 0, out_of = 0.
- ZF = 1, SF = 0, OF = 0.
- in_ready = 1 in the first cycle after reset.
- Reset mid-operation discards both stages; no CC update occurs on a reset cycle, even if out_ready = 1.

## Timing
- Latency 2: an input accepted at edge N appears with out_valid = 1 after edge N+1.
- Throughput: one operation per cycle when out_ready stays 1.
- Backpressure: with out_ready = 0, two operations are buffered, then in_ready drops to 0. It rises combinationally in the cycle out_ready returns to 1.
- Simultaneous accept-in and accept-out with both stages full: both stages advance in the same edge, with no bubble.
- out_result/out_of are stable while out_valid && !out_ready.
- CC changes at the same edge the producing result is consumed. cond_true reflects the new CC from the following cycle.
- in_valid with in_ready = 0: no capture. The producer holds its data (AXI-style, not checked).

## Test plan
1. **Reset defaults:** assert rst 2 cycles → out_valid = 0, in_ready = 1, ZF = 1/SF = 0/OF = 0, cond_true = 1 for cond_fun = 3 (e) and 0 for cond_fun = 4 (ne).
2. **Signed overflow (WIDTH = 64), out_ready = 1:**
   - sub with a = 0x8000_0000_0000_0000, b = 1, set_cc → out_result = 0x7FFF_FFFF_FFFF_FFFF, out_of = 1, 2 cycles after accept.
   - Afterwards ZF = 0, SF = 0, OF = 1, and cond 2 (l) = 1.
3. **Zero and CC hold:**
   - sub a = 5, b = 5 with set_cc → ZF = 1, cond 6 (g) = 0.
   - Then add a = 1, b = 1 without set_cc → out_result = 2, CC unchanged.
4. **Logic ops:** and 0xF0F0, 0xFF00 → 0xF000, OF = 0; xor 0xF0F0, 0xFF00 → 0x0FF0, OF = 0.
5. **Backpressure:**
   - Stream 4 adds (i + i for i = 1..4) with out_ready = 0 → in_ready falls after 2 accepts.
   - Release out_ready → outputs 2, 4, 6, 8 in order, with none lost or duplicated.
   - Repeat with WIDTH = 8: add 0x7F + 0x01 → 0x80, OF = 1.
6. **Reset mid-stream:** both stages full, set_cc pending; assert rst with out_ready = 1 → out_valid = 0 next cycle, CC = reset values, first post-reset op latency = 2.

Source files
------------

// File: rtl/y86_alu_pipe_if.sv
// Handshake bundle for the Y86 execute ALU: operand channel in, result channel out.
interface y86_alu_pipe_if #(
  parameter int unsigned WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [1:0]       in_fun;
  logic             in_set_cc;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_of;

  modport master (
    output in_valid, in_a, in_b, in_fun, in_set_cc, out_ready,
    input  in_ready, out_valid, out_result, out_of
  );

  modport slave (
    input  in_valid, in_a, in_b, in_fun, in_set_cc, out_ready,
    output in_ready, out_valid, out_result, out_of
  );
endinterface

// File: rtl/y86_alu_pipe.sv
// Two-stage pipelined Y86-64 OPq ALU with condition-code register and jXX/cmovXX evaluation.
module y86_alu_pipe #(
  parameter int unsigned WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  y86_alu_pipe_if.slave        bus,
  output logic                 cc_zf,
  output logic                 cc_sf,
  output logic                 cc_of,
  input  logic [2:0]           cond_fun,
  output logic                 cond_true
);
  localparam int unsigned MSB = WIDTH - 1;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic [1:0]       s1_fun_q, s1_fun_d;
  logic             s1_set_cc_q, s1_set_cc_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_result_q, s2_result_d;
  logic             s2_of_q, s2_of_d;
  logic             s2_set_cc_q, s2_set_cc_d;

  logic             cc_zf_q, cc_zf_d;
  logic             cc_sf_q, cc_sf_d;
  logic             cc_of_q, cc_of_d;

  logic             s1_load, s2_load, cc_update, lt;
  logic [WIDTH-1:0] sum, diff, alu_res;
  logic             alu_of;

  assign s2_load   = !s2_valid_q || bus.out_ready;
  assign s1_load   = !s1_valid_q || s2_load;
  assign cc_update = s2_valid_q && bus.out_ready && s2_set_cc_q;

  assign sum  = s1_a_q + s1_b_q;
  assign diff = s1_a_q - s1_b_q;

  // Execute: overflow is judged from operand and result sign bits.
  always_comb begin
    alu_res = '0;
    alu_of  = 1'b0;
    case (s1_fun_q)
      2'd0: begin
        alu_res = sum;
        alu_of  = (s1_a_q[MSB] == s1_b_q[MSB]) && (sum[MSB] != s1_a_q[MSB]);
      end
      2'd1: begin
        alu_res = diff;
        alu_of  = (s1_a_q[MSB] != s1_b_q[MSB]) && (diff[MSB] != s1_a_q[MSB]);
      end
      2'd2:    alu_res = s1_a_q & s1_b_q;
      default: alu_res = s1_a_q ^ s1_b_q;
    endcase
  end

  // Next state: a stage whose successor stalls keeps its contents.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_fun_d    = s1_fun_q;
    s1_set_cc_d = s1_set_cc_q;
    s2_valid_d  = s2_valid_q;
    s2_result_d = s2_result_q;
    s2_of_d     = s2_of_q;
    s2_set_cc_d = s2_set_cc_q;
    cc_zf_d     = cc_zf_q;
    cc_sf_d     = cc_sf_q;
    cc_of_d     = cc_of_q;

    if (s1_load) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_a_d      = bus.in_a;
        s1_b_d      = bus.in_b;
        s1_fun_d    = bus.in_fun;
        s1_set_cc_d = bus.in_set_cc;
      end
    end

    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_result_d = alu_res;
        s2_of_d     = alu_of;
        s2_set_cc_d = s1_set_cc_q;
      end
    end

    if (cc_update) begin
      cc_zf_d = (s2_result_q == '0);
      cc_sf_d = s2_result_q[MSB];
      cc_of_d = s2_of_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_fun_q    <= 2'd0;
      s1_set_cc_q <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_of_q     <= 1'b0;
      s2_set_cc_q <= 1'b0;
      cc_zf_q     <= 1'b1;
      cc_sf_q     <= 1'b0;
      cc_of_q     <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_fun_q    <= s1_fun_d;
      s1_set_cc_q <= s1_set_cc_d;
      s2_valid_q  <= s2_valid_d;
      s2_result_q <= s2_result_d;
      s2_of_q     <= s2_of_d;
      s2_set_cc_q <= s2_set_cc_d;
      cc_zf_q     <= cc_zf_d;
      cc_sf_q     <= cc_sf_d;
      cc_of_q     <= cc_of_d;
    end
  end

  // Y86 branch/cmov conditions from the architectural CC register.
  assign lt = cc_sf_q ^ cc_of_q;
  always_comb begin
    cond_true = 1'b0;
    case (cond_fun)
      3'd0:    cond_true = 1'b1;
      3'd1:    cond_true = lt | cc_zf_q;
      3'd2:    cond_true = lt;
      3'd3:    cond_true = cc_zf_q;
      3'd4:    cond_true = !cc_zf_q;
      3'd5:    cond_true = !lt;
      3'd6:    cond_true = !lt && !cc_zf_q;
      default: cond_true = 1'b0;
    endcase
  end

  assign bus.in_ready   = s1_load;
  assign bus.out_valid  = s2_valid_q;
  assign bus.out_result = s2_result_q;
  assign bus.out_of     = s2_of_q;
  assign cc_zf          = cc_zf_q;
  assign cc_sf          = cc_sf_q;
  assign cc_of          = cc_of_q;
endmodule

// File: tb/tb_y86_alu_pipe.sv
// Randomised and directed bench for y86_alu_pipe against a queue-based reference model.
module tb_y86_alu_pipe;
  localparam int unsigned W  = 64;
  localparam int unsigned WX = W + 2;
  localparam int unsigned W8 = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  y86_alu_pipe_if #(.WIDTH(W))  bus  ();
  y86_alu_pipe_if #(.WIDTH(W8)) bus8 ();

  logic [2:0] cond_fun, cond_fun8;
  logic cc_zf, cc_sf, cc_of, cond_true;
  logic cc8_zf, cc8_sf, cc8_of, cond8_true;

  y86_alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of),
    .cond_fun(cond_fun), .cond_true(cond_true)
  );

  y86_alu_pipe #(.WIDTH(W8)) dut8 (
    .clk(clk), .rst(rst), .bus(bus8.slave),
    .cc_zf(cc8_zf), .cc_sf(cc8_sf), .cc_of(cc8_of),
    .cond_fun(cond_fun8), .cond_true(cond8_true)
  );

  typedef struct packed {
    logic [W-1:0] r;
    logic         of;
    logic         sc;
  } exp_t;

  int checks = 0;
  int failures = 0;

  exp_t exp_q[$];
  logic m_zf, m_sf, m_of;

  logic         o_in_ready, o_out_valid, o_of, o_zf, o_sf, o_ccof, o_cond;
  logic [W-1:0] o_res;
  logic         e_in_ready, e_zf, e_sf, e_of, e_cond, e_ovf, have_exp;
  logic [W-1:0] e_res;
  logic         in_fire, out_fire;

  // Exact signed arithmetic in a wider type; overflow = result out of W-bit range.
  function automatic exp_t ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [1:0] fun, input logic sc);
    logic signed [WX-1:0] xa, xb, s, hi, lo;
    exp_t e;
    xa = WX'($signed(a));
    xb = WX'($signed(b));
    hi = (WX'(1) <<< (W - 1)) - WX'(1);
    lo = -hi - WX'(1);
    s  = '0;
    e.sc = sc;
    e.of = 1'b0;
    e.r  = '0;
    case (fun)
      2'd0: begin s = xa + xb; e.r = s[W-1:0]; e.of = (s > hi) || (s < lo); end
      2'd1: begin s = xa - xb; e.r = s[W-1:0]; e.of = (s > hi) || (s < lo); end
      2'd2: e.r = a & b;
      default: e.r = a ^ b;
    endcase
    return e;
  endfunction

  function automatic logic ref_cond(input logic [2:0] cf, input logic zf, input logic sf,
                                    input logic of);
    logic less, equal;
    less  = (sf != of);
    equal = zf;
    case (cf)
      3'd0: return 1'b1;
      3'd1: return less || equal;
      3'd2: return less;
      3'd3: return equal;
      3'd4: return !equal;
      3'd5: return !less;
      3'd6: return !less && !equal;
      default: return 1'b0;
    endcase
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    m_zf = 1'b1;
    m_sf = 1'b0;
    m_of = 1'b0;
  endfunction

  // One clock: drive at negedge, observe, advance the model, then take the edge.
  task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [1:0] fun, input logic sc, input logic ordy,
                      input logic [2:0] cf);
    exp_t e;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_fun    = fun;
    bus.in_set_cc = sc;
    bus.out_ready = ordy;
    cond_fun      = cf;
    #1;
    o_in_ready  = bus.in_ready;
    o_out_valid = bus.out_valid;
    o_res       = bus.out_result;
    o_of        = bus.out_of;
    o_zf        = cc_zf;
    o_sf        = cc_sf;
    o_ccof      = cc_of;
    o_cond      = cond_true;
    e_zf        = m_zf;
    e_sf        = m_sf;
    e_of        = m_of;
    e_cond      = ref_cond(cf, m_zf, m_sf, m_of);
    e_in_ready  = (exp_q.size() < 2) || ordy;
    in_fire     = v && o_in_ready;
    out_fire    = o_out_valid && ordy;
    have_exp    = 1'b0;
    e_res       = '0;
    e_ovf       = 1'b0;
    if (out_fire && exp_q.size() > 0) begin
      e        = exp_q.pop_front();
      have_exp = 1'b1;
      e_res    = e.r;
      e_ovf    = e.of;
      if (e.sc) begin
        m_zf = (e.r == '0);
        m_sf = e.r[W-1];
        m_of = e.of;
      end
    end
    if (in_fire) exp_q.push_back(ref_op(a, b, fun, sc));
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cond_fun = 3'd3;
    model_reset();
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    checks++; if ({cc_zf, cc_sf, cc_of} !== 3'b100) begin failures++; $display("FAIL reset_cc got=%b%b%b exp=100", cc_zf, cc_sf, cc_of); end
    checks++; if (bus.out_result !== '0 || bus.out_of !== 1'b0) begin failures++; $display("FAIL reset_out got=%h/%b exp=0/0", bus.out_result, bus.out_of); end
    checks++; if (cond_true !== 1'b1) begin failures++; $display("FAIL reset_cond_e got=%b exp=1", cond_true); end
    cond_fun = 3'd4;
    #1;
    checks++; if (cond_true !== 1'b0) begin failures++; $display("FAIL reset_cond_ne got=%b exp=0", cond_true); end
    checks++; if (bus8.out_valid !== 1'b0 || bus8.in_ready !== 1'b1 || cc8_zf !== 1'b1) begin failures++; $display("FAIL reset_w8 got=v%b r%b z%b exp=v0 r1 z1", bus8.out_valid, bus8.in_ready, cc8_zf); end
  endtask

  task automatic test_overflow();
    step(1'b1, 64'h8000_0000_0000_0000, 64'd1, 2'd1, 1'b1, 1'b1, 3'd2);
    checks++; if (in_fire !== 1'b1) begin failures++; $display("FAIL ovf_accept got=%b exp=1", in_fire); end
    step(1'b0, '0, '0, 2'd0, 1'b0, 1'b1, 3'd2);
    checks++; if (o_out_valid !== 1'b0) begin failures++; $display("FAIL ovf_early got=%b exp=0", o_out_valid); end
    step(1'b0, '0, '0, 2'd0, 1'b0, 1'b1, 3'd2);
    checks++; if (o_out_valid !== 1'b1 || o_res !== 64'h7FFF_FFFF_FFFF_FFFF || o_of !== 1'b1) begin failures++; $display("FAIL ovf_result got=v%b %h of%b exp=v1 7fffffffffffffff of1", o_out_valid, o_res, o_of); end
    step(1'b0, '0, '0, 2'd0, 1'b0, 1'b1, 3'd2);
    checks++; if ({o_zf, o_sf, o_ccof} !== 3'b001 || o_cond !== 1'b1) begin failures++; $display("FAIL ovf_cc got=%b%b%b l=%b exp=001 l=1", o_zf, o_sf, o_ccof, o_cond); end
  endtask

  task automatic test_zero_hold();
    step(1'b1, 64'd5, 64'd5, 2'd1, 1'b1, 1'b1, 3'd6);
    step(1'b0, '0, '0, 2'd0, 1'b0, 1'b1, 3'd6);
    step(1'b0, '0, '0, 2'd0, 1'b0, 1'b1, 3'd6);
    checks++; if (o_out_valid !== 1'b1 || o_res !== '0 || o_of !== 1'b0) begin failures++; $display("FAIL zero_result got=v%b %h of%b exp=v1 0 of0", o_out_valid, o_res, o_of); end
    step(1'b1, 64'd1, 64'd1, 2'd0, 1'b0, 1'b1, 3'd6);
    checks++; if (o_zf !== 1'b1 || o_cond !== 1'b0) begin failures++; $display("FAIL zero_cc got=z%b g%b exp=z1 g0", o_zf, o_cond); end
    step(1'b0, '0, '0, 2'd0, 1'b0, 1'b1, 3'd3);
    step(1'b0, '0, '0, 2'd0, 1'b0, 1'b1, 3'd3);
    checks++; if (o_out_valid !== 1'b1 || o_res !== 64'd2) begin failures++; $display("FAIL hold_result got=v%b %h exp=v1 2", o_out_valid, o_res); end
    step(1'b0, '0, '0, 2'd0, 1'b0, 1'b1, 3'd3);
    checks++; if ({o_zf, o_sf, o_ccof} !== 3'b100 || o_cond !== 1'b1) begin failures++; $display("FAIL hold_cc got=%b%b%b e=%b exp=100 e=1", o_zf, o_sf, o_ccof, o_cond); end
  endtask

  task automatic test_logic();
    step(1'b1, 64'hF0F0, 64'hFF00, 2'd2, 1'b0, 1'b1, 3'd0);
    step(1'b1, 64'hF0F0, 64'hFF00, 2'd3, 1'b0, 1'b1, 3'd0);
    step(1'b0, '0, '0, 2'd0, 1'b0, 1'b1, 3'd0);
    checks++; if (o_out_valid !== 1'b1 || o_res !== 64'hF000 || o_of !== 1'b0) begin failures++; $display("FAIL logic_and got=v%b %h of%b exp=v1 f000 of0", o_out_valid, o_res, o_of); end
    step(1'b0, '0, '0, 2'd0, 1'b0, 1'b1, 3'd0);
    checks++; if (o_out_valid !== 1'b1 || o_res !== 64'h0FF0 || o_of !== 1'b0) begin failures++; $display("FAIL logic_xor got=v%b %h of%b exp=v1 0ff0 of0", o_out_valid, o_res, o_of); end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    int got = 0;
    for (int c = 0; c < 4; c++) begin
      step(acc < 4, W'(acc + 1), W'(acc + 1), 2'd0, 1'b0, 1'b0, 3'd0);
      if (in_fire) acc++;
      if (c >= 2) begin
        checks++; if (o_out_valid !== 1'b1 || o_res !== 64'd2) begin failures++; $display("FAIL bp_stable c=%0d got=v%b %h exp=v1 2", c, o_out_valid, o_res); end
      end
    end
    checks++; if (acc != 2 || o_in_ready !== 1'b0) begin failures++; $display("FAIL bp_full got=acc%0d rdy%b exp=acc2 rdy0", acc, o_in_ready); end
    for (int c = 0; c < 20 && got < 4; c++) begin
      step(acc < 4, W'(acc + 1), W'(acc + 1), 2'd0, 1'b0, 1'b1, 3'd0);
      if (c == 0) begin
        checks++; if (o_in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", o_in_ready); end
      end
      if (out_fire) begin
        checks++; if (o_res !== W'(2 * (got + 1))) begin failures++; $display("FAIL bp_order n=%0d got=%h exp=%h", got, o_res, W'(2 * (got + 1))); end
        got++;
      end
      if (in_fire) acc++;
    end
    checks++; if (got != 4 || acc != 4) begin failures++; $display("FAIL bp_count got=out%0d in%0d exp=4/4", got, acc); end
    step(1'b0, '0, '0, 2'd0, 1'b0, 1'b1, 3'd0);
    checks++; if (o_out_valid !== 1'b0) begin failures++; $display("FAIL bp_dup got=%b exp=0", o_out_valid); end
  endtask

  task automatic test_width8();
    @(negedge clk);
    bus8.in_valid = 1'b1; bus8.in_a = 8'h7F; bus8.in_b = 8'h01;
    bus8.in_fun = 2'd0; bus8.in_set_cc = 1'b1; bus8.out_ready = 1'b0; cond_fun8 = 3'd2;
    #1;
    checks++; if (bus8.in_ready !== 1'b1) begin failures++; $display("FAIL w8_ready got=%b exp=1", bus8.in_ready); end
    @(posedge clk);
    @(negedge clk);
    bus8.in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      checks++; if (bus8.out_valid !== 1'b1 || bus8.out_result !== 8'h80 || bus8.out_of !== 1'b1 || cc8_zf !== 1'b1) begin failures++; $display("FAIL w8_hold c=%0d got=v%b %h of%b z%b exp=v1 80 of1 z1", c, bus8.out_valid, bus8.out_result, bus8.out_of, cc8_zf); end
    end
    bus8.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus8.out_ready = 1'b0;
    #1;
    checks++; if (bus8.out_valid !== 1'b0 || {cc8_zf, cc8_sf, cc8_of} !== 3'b011 || cond8_true !== 1'b0) begin failures++; $display("FAIL w8_cc got=v%b %b%b%b l%b exp=v0 011 l0", bus8.out_valid, cc8_zf, cc8_sf, cc8_of, cond8_true); end
  endtask

  task automatic test_reset_mid();
    int acc = 0;
    for (int c = 0; c < 4 && acc < 2; c++) begin
      step(1'b1, 64'd0, 64'd1, 2'd1, 1'b1, 1'b0, 3'd0);
      if (in_fire) acc++;
    end
    step(1'b0, '0, '0, 2'd0, 1'b0, 1'b0, 3'd0);
    checks++; if (acc != 2 || o_in_ready !== 1'b0 || o_out_valid !== 1'b1) begin failures++; $display("FAIL mid_fill got=acc%0d rdy%b v%b exp=2 0 1", acc, o_in_ready, o_out_valid); end
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    cond_fun = 3'd0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin failures++; $display("FAIL mid_flush got=v%b r%b exp=v0 r1", bus.out_valid, bus.in_ready); end
    checks++; if ({cc_zf, cc_sf, cc_of} !== 3'b100) begin failures++; $display("FAIL mid_cc got=%b%b%b exp=100", cc_zf, cc_sf, cc_of); end
    step(1'b1, 64'd7, 64'd3, 2'd1, 1'b1, 1'b1, 3'd0);
    step(1'b0, '0, '0, 2'd0, 1'b0, 1'b1, 3'd0);
    checks++; if (o_out_valid !== 1'b0) begin failures++; $display("FAIL mid_lat_early got=%b exp=0", o_out_valid); end
    step(1'b0, '0, '0, 2'd0, 1'b0, 1'b1, 3'd0);
    checks++; if (o_out_valid !== 1'b1 || o_res !== 64'd4) begin failures++; $display("FAIL mid_lat got=v%b %h exp=v1 4", o_out_valid, o_res); end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    for (int c = 0; c < 400; c++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: b = a;
        1: begin a = 64'h8000_0000_0000_0000 ^ W'($urandom_range(0, 3)); b = W'($urandom_range(0, 3)); end
        2: a = 64'h7FFF_FFFF_FFFF_FFFF;
        default: ;
      endcase
      step($urandom_range(0, 3) != 0, a, b, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)));
      checks++; if (o_in_ready !== e_in_ready) begin failures++; $display("FAIL rnd_in_ready c=%0d got=%b exp=%b", c, o_in_ready, e_in_ready); end
      checks++; if ({o_zf, o_sf, o_ccof, o_cond} !== {e_zf, e_sf, e_of, e_cond}) begin failures++; $display("FAIL rnd_cc c=%0d got=%b%b%b c%b exp=%b%b%b c%b", c, o_zf, o_sf, o_ccof, o_cond, e_zf, e_sf, e_of, e_cond); end
      if (out_fire) begin
        checks++; if (!have_exp || o_res !== e_res || o_of !== e_ovf) begin failures++; $display("FAIL rnd_result c=%0d got=%h of%b exp=%h of%b have=%b", c, o_res, o_of, e_res, e_ovf, have_exp); end
      end
    end
    for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
      step(1'b0, '0, '0, 2'd0, 1'b0, 1'b1, 3'd0);
      if (out_fire) begin
        checks++; if (!have_exp || o_res !== e_res || o_of !== e_ovf) begin failures++; $display("FAIL rnd_drain got=%h of%b exp=%h of%b", o_res, o_of, e_res, e_ovf); end
      end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rnd_drain_empty got=%0d exp=0", exp_q.size()); end
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_fun = 2'd0;
    bus.in_set_cc = 1'b0; bus.out_ready = 1'b0; cond_fun = 3'd0;
    bus8.in_valid = 1'b0; bus8.in_a = '0; bus8.in_b = '0; bus8.in_fun = 2'd0;
    bus8.in_set_cc = 1'b0; bus8.out_ready = 1'b0; cond_fun8 = 3'd0;
    model_reset();
    test_reset();
    test_overflow();
    test_zero_hold();
    test_logic();
    test_backpressure();
    test_width8();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
